// File: rtl/lockstep_pkg.sv
// Shared types and defaults for the lockstep mismatch monitor.
// The FSM state encoding is visible on the monitor's state port, so it lives here.
package lockstep_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    ARMED   = 2'd1,
    SUSPECT = 2'd2,
    ALARM   = 2'd3
  } mon_state_e;

  localparam int DEF_LENGTH        = 32;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WARMUP_CYCLES = 3;
  localparam int DEF_ALARM_THRESH  = 4;

  // A sample is a real mismatch only when the comparator output is valid.
  function automatic logic is_mismatch(input logic valid, input logic equal);
    return valid & ~equal;
  endfunction

endpackage

// File: rtl/lockstep_mismatch_monitor_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// It holds at all-ones instead of wrapping, so a flood of mismatches never reads back as a small count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count register: reset and clear both take priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/lockstep_mismatch_monitor.sv
// Lockstep mismatch monitor.
// It ignores the comparator warm-up window and filters out isolated mismatches.
// A run of ALARM_THRESH consecutive valid mismatches raises a sticky alarm.
// The alarm is released only by the clr_req/clr_ack handshake.
// Optional feature macro: MISMATCH_CAPTURE_EN captures the data of the first mismatch.
module lockstep_mismatch_monitor
  import lockstep_pkg::*;
#(
  parameter int LENGTH        = DEF_LENGTH,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int ALARM_THRESH  = DEF_ALARM_THRESH,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmp_valid,
  input  logic              equal,
  input  logic [LENGTH-1:0] exp_data,
  input  logic [LENGTH-1:0] act_data,
  input  logic              clr_req,
  output logic              clr_ack,
  output logic              alarm,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [LENGTH-1:0] first_exp,
  output logic [LENGTH-1:0] first_act
);

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int CONS_W = $clog2(ALARM_THRESH + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(ALARM_THRESH - 1);

  mon_state_e        state_r, state_s;
  logic [WARM_W-1:0] warm_r, warm_s;
  logic [CONS_W-1:0] consec_r, consec_s;
  logic              ack_armed_r;
  logic              clear_fire_s;
  logic              cnt_inc_s;
  logic              mism_s;

  assign state = state_r;

  // State register, warm-up sample count and consecutive-mismatch run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= WARMUP;
      warm_r   <= '0;
      consec_r <= '0;
    end else begin
      state_r  <= state_s;
      warm_r   <= warm_s;
      consec_r <= consec_s;
    end
  end

  // Next-state logic. An accepted clear overrides whatever the sample would have done.
  always_comb begin
    state_s  = state_r;
    warm_s   = warm_r;
    consec_s = consec_r;
    if (clear_fire_s) begin
      state_s  = ARMED;
      consec_s = '0;
    end else begin
      case (state_r)
        WARMUP: begin
          if (WARMUP_CYCLES == 0) begin
            state_s = ARMED;
          end else if (cmp_valid) begin
            if (warm_r == WARM_LAST) begin
              state_s = ARMED;
            end else begin
              warm_s = warm_r + WARM_W'(1);
            end
          end else begin
            warm_s = warm_r;
          end
        end
        ARMED: begin
          if (mism_s) begin
            consec_s = CONS_W'(1);
            state_s  = (ALARM_THRESH == 1) ? ALARM : SUSPECT;
          end else begin
            consec_s = '0;
          end
        end
        SUSPECT: begin
          if (mism_s) begin
            consec_s = consec_r + CONS_W'(1);
            if (consec_r == CONS_LAST) begin
              state_s = ALARM;
            end else begin
              state_s = SUSPECT;
            end
          end else if (cmp_valid) begin
            consec_s = '0;
            state_s  = ARMED;
          end else begin
            state_s = SUSPECT;
          end
        end
        ALARM: begin
          state_s = ALARM;
        end
        default: begin
          state_s  = WARMUP;
          consec_s = '0;
        end
      endcase
    end
  end

  // Output decode.
  // A clear is accepted only once warm-up is over and the previous request has been released.
  // A sample that coincides with an accepted clear is dropped.
  always_comb begin
    mism_s       = is_mismatch(cmp_valid, equal);
    clear_fire_s = clr_req & ack_armed_r & (state_r != WARMUP);
    if (clear_fire_s) begin
      cnt_inc_s = 1'b0;
    end else begin
      cnt_inc_s = mism_s & (state_r != WARMUP);
    end
  end

  // Registered handshake and alarm outputs. ack_armed re-arms only after clr_req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ack     <= 1'b0;
      alarm       <= 1'b0;
      ack_armed_r <= 1'b1;
    end else begin
      clr_ack <= clear_fire_s;
      alarm   <= (state_s == ALARM);
      if (clear_fire_s) begin
        ack_armed_r <= 1'b0;
      end else if (!clr_req) begin
        ack_armed_r <= 1'b1;
      end else begin
        ack_armed_r <= ack_armed_r;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc_s),
    .clr   (clear_fire_s),
    .count (mismatch_cnt)
  );

`ifdef MISMATCH_CAPTURE_EN
  logic captured_r;

  // Capture exp/act of the first counted mismatch; hold the data until the next clear or reset.
  always_ff @(posedge clk) begin
    if (rst || clear_fire_s) begin
      captured_r <= 1'b0;
      first_exp  <= '0;
      first_act  <= '0;
    end else if (cnt_inc_s && !captured_r) begin
      captured_r <= 1'b1;
      first_exp  <= exp_data;
      first_act  <= act_data;
    end else begin
      captured_r <= captured_r;
      first_exp  <= first_exp;
      first_act  <= first_act;
    end
  end
`else
  logic unused_data_s;
  assign unused_data_s = ^{exp_data, act_data};
  assign first_exp     = '0;
  assign first_act     = '0;
`endif

endmodule
